regfile_wb_arbiter: RTL and testbench

// Shares the register bank's single write port between two writeback sources:
//   - A: the ALU (single-cycle results).
//   - B: the load/store unit (load data).

---
 rtl/regfile_wb_arbiter_if.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle between the two writeback sources and the arbiter.
//
// Signals:
//   a_valid/a_ready/a_addr/a_data  ALU writeback request channel
//   b_valid/b_ready/b_addr/b_data  LSU writeback request channel
//
// Handshake: a transfer happens on the cycle valid && ready. The requester keeps
// valid/addr/data stable until it sees ready. The arbiter raises at most one
// ready per cycle, and raises none while the matching valid is low.
//
// Modports:
//   master  requester side (drives valid/addr/data, observes ready)
//   slave   arbiter side (observes valid/addr/data, drives ready)
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            a_valid;
  logic            a_ready;
  logic [4:0]      a_addr;
  logic [XLEN-1:0] a_data;
  logic            b_valid;
  logic            b_ready;
  logic [4:0]      b_addr;
  logic [XLEN-1:0] b_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register bank's single write port between the ALU (A) and the
// load/store unit (B), and keeps a per-register busy scoreboard for decode.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   wb                    A/B writeback request channels (slave modport)
//   issue_valid/addr      decode issued an instruction writing issue_addr
//   rs1_addr/rs2_addr     decode operand queries
//   rs1_busy/rs2_busy     operand has a pending write (from state only)
//   write_register_addr   register bank write address (registered)
//   write_data            register bank write data (registered)
//   write_enable          register bank write strobe (registered)
//
// Arbitration: B wins contention, except when A has already lost STARVE_LIMIT
// consecutive contended cycles; then A is forced through once.
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  regfile_wb_arbiter_if.slave wb,
  input  logic            issue_valid,
  input  logic [4:0]      issue_addr,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [4:0]      write_register_addr,
  output logic [XLEN-1:0] write_data,
  output logic            write_enable
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        starve_hit;
  logic        a_grant;
  logic        b_grant;
  logic [31:0] busy;
  logic [31:0] busy_next;

  always_comb begin
    starve_hit = (starve_cnt == LIMIT);
    a_grant    = !rst && wb.a_valid && (!wb.b_valid || starve_hit);
    b_grant    = !rst && wb.b_valid && !(wb.a_valid && starve_hit);
    wb.a_ready = a_grant;
    wb.b_ready = b_grant;
  end

  // Set is applied after clear so a new producer issued in the write cycle
  // keeps the register marked busy.
  always_comb begin
    busy_next = busy;
    if (write_enable) busy_next[write_register_addr] = 1'b0;
    if (issue_valid && issue_addr != 5'd0) busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable        <= 1'b0;
      write_register_addr <= 5'd0;
      write_data          <= '0;
      starve_cnt          <= 4'd0;
      busy                <= 32'd0;
    end else begin
      write_enable <= 1'b0;
      if (a_grant) begin
        write_register_addr <= wb.a_addr;
        write_data          <= wb.a_data;
        write_enable        <= (wb.a_addr != 5'd0);
      end else if (b_grant) begin
        write_register_addr <= wb.b_addr;
        write_data          <= wb.b_data;
        write_enable        <= (wb.b_addr != 5'd0);
      end

      // b_grant with a_valid high means A lost a contended cycle.
      if (!wb.a_valid || a_grant) begin
        starve_cnt <= 4'd0;
      end else if (b_grant && !starve_hit) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      issue_addr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [4:0]      write_register_addr;
  logic [XLEN-1:0] write_data;
  logic            write_enable;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) wb ();

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .wb                  (wb),
    .issue_valid         (issue_valid),
    .issue_addr          (issue_addr),
    .rs1_addr            (rs1_addr),
    .rs2_addr            (rs2_addr),
    .rs1_busy            (rs1_busy),
    .rs2_busy            (rs2_busy),
    .write_register_addr (write_register_addr),
    .write_data          (write_data),
    .write_enable        (write_enable)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ar;
    logic        e_br;
    logic        e_r1b;
    logic        e_r2b;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];
  int   n_pass;
  int   n_total;

  localparam logic [31:0] A3 = 32'hAAAA_0003;
  localparam logic [31:0] B4 = 32'hBBBB_0004;

  function automatic vec_t mk(
    input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic bv, input logic [4:0] ba, input logic [31:0] bd,
    input logic iv, input logic [4:0] ia,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic ear, input logic ebr, input logic er1, input logic er2,
    input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.iv = iv; v.ia = ia; v.r1 = r1; v.r2 = r2;
    v.e_ar = ear; v.e_br = ebr; v.e_r1b = er1; v.e_r2b = er2;
    v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    wb.a_valid = 1'b0; wb.a_addr = 5'd0; wb.a_data = '0;
    wb.b_valid = 1'b0; wb.b_addr = 5'd0; wb.b_data = '0;
    issue_valid = 1'b0; issue_addr = 5'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  task automatic drive_vec(input vec_t v);
    wb.a_valid = v.av; wb.a_addr = v.aa; wb.a_data = v.ad;
    wb.b_valid = v.bv; wb.b_addr = v.ba; wb.b_data = v.bd;
    issue_valid = v.iv; issue_addr = v.ia;
    rs1_addr = v.r1; rs2_addr = v.r2;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive_vec(v);
    #1;
    check($sformatf("v%0d a_ready", idx), {31'd0, wb.a_ready}, {31'd0, v.e_ar});
    check($sformatf("v%0d b_ready", idx), {31'd0, wb.b_ready}, {31'd0, v.e_br});
    check($sformatf("v%0d rs1_busy", idx), {31'd0, rs1_busy}, {31'd0, v.e_r1b});
    check($sformatf("v%0d rs2_busy", idx), {31'd0, rs2_busy}, {31'd0, v.e_r2b});
    @(posedge clk);
    #1;
    check($sformatf("v%0d write_enable", idx), {31'd0, write_enable}, {31'd0, v.e_we});
    check($sformatf("v%0d write_addr", idx), {27'd0, write_register_addr}, {27'd0, v.e_wa});
    check($sformatf("v%0d write_data", idx), write_data, v.e_wd);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    // stimulus table
    vecs.push_back(mk(1,5,32'hDEADBEEF, 0,0,0, 0,0, 5,0, 1,0,0,0, 1,5,32'hDEADBEEF));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 5,0, 0,0,0,0, 0,5,32'hDEADBEEF));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 7,0, 0,0,0,0, 0,5,32'hDEADBEEF));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 7,5, 0,0,1,0, 0,5,32'hDEADBEEF));
    vecs.push_back(mk(0,0,0, 1,7,32'h0000_1111, 0,0, 7,0, 0,1,1,0, 1,7,32'h0000_1111));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 7,0, 0,0,1,0, 0,7,32'h0000_1111));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 7,0, 0,0,0,0, 0,7,32'h0000_1111));
    // x0 load accepted without a strobe; issue to x0 must not mark x0 busy
    vecs.push_back(mk(0,0,0, 1,0,32'h0000_1234, 1,0, 7,0, 0,1,0,0, 0,0,32'h0000_1234));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,7, 0,0,0,0, 0,0,32'h0000_1234));
    // held contention: B,B,B,B,A,B,B,B,B,A
    for (int i = 0; i < 10; i++) begin
      logic aw;
      aw = (i == 4) || (i == 9);
      vecs.push_back(mk(1,3,A3, 1,4,B4, 0,0, 3,4, aw,!aw,0,0, 1, aw ? 5'd3 : 5'd4, aw ? A3 : B4));
    end
    // three B wins, then a_valid low must clear the starvation count
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,3,A3, 1,4,B4, 0,0, 3,4, 0,1,0,0, 1,4,B4));
    vecs.push_back(mk(0,0,0, 1,4,B4, 0,0, 3,4, 0,1,0,0, 1,4,B4));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,3,A3, 1,4,B4, 0,0, 3,4, 0,1,0,0, 1,4,B4));
    vecs.push_back(mk(1,3,A3, 1,4,B4, 0,0, 3,4, 1,0,0,0, 1,3,A3));
    // re-issue to x7 in the write cycle keeps it busy
    vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 7,0, 0,0,0,0, 0,3,A3));
    vecs.push_back(mk(0,0,0, 1,7,32'h0000_0077, 0,0, 7,0, 0,1,1,0, 1,7,32'h0000_0077));
    vecs.push_back(mk(0,0,0, 0,0,0, 1,7, 7,0, 0,0,1,0, 0,7,32'h0000_0077));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 7,7, 0,0,1,1, 0,7,32'h0000_0077));

    // reset block: requests pending during reset must not be accepted
    drive_idle();
    rst = 1'b1;
    wb.a_valid = 1'b1; wb.a_addr = 5'd1; wb.a_data = 32'h1;
    wb.b_valid = 1'b1; wb.b_addr = 5'd2; wb.b_data = 32'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst a_ready", {31'd0, wb.a_ready}, 32'd0);
    check("rst b_ready", {31'd0, wb.b_ready}, 32'd0);
    check("rst write_enable", {31'd0, write_enable}, 32'd0);
    check("rst write_addr", {27'd0, write_register_addr}, 32'd0);
    check("rst write_data", write_data, 32'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      #1;
      check($sformatf("rst rs1_busy[%0d]", i), {31'd0, rs1_busy}, 32'd0);
    end

    @(negedge clk);
    rst = 1'b0;
    drive_idle();

    for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

    // reset while a granted result sits on the write port
    @(negedge clk);
    drive_idle();
    issue_valid = 1'b1; issue_addr = 5'd9;
    @(negedge clk);
    drive_idle();
    wb.a_valid = 1'b1; wb.a_addr = 5'd9; wb.a_data = 32'h0000_0099;
    rs1_addr = 5'd9;
    #1;
    check("mid a_ready", {31'd0, wb.a_ready}, 32'd1);
    check("mid busy9 before", {31'd0, rs1_busy}, 32'd1);
    @(posedge clk);
    #1;
    check("mid write_enable", {31'd0, write_enable}, 32'd1);
    check("mid write_addr", {27'd0, write_register_addr}, 32'd9);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst a_ready", {31'd0, wb.a_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("mid rst write_enable", {31'd0, write_enable}, 32'd0);
    check("mid rst write_addr", {27'd0, write_register_addr}, 32'd0);
    check("mid rst write_data", write_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    rs1_addr = 5'd9;
    #1;
    check("mid busy9 after", {31'd0, rs1_busy}, 32'd0);
    check("mid idle a_ready", {31'd0, wb.a_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("mid idle write_enable", {31'd0, write_enable}, 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
